// File: rtl/parallel_serial_scheduler.sv
// Byte-slot scheduler: round-robin grants one requester per 8-cycle slot and
// presents its byte to a shared parallel-to-serial converter for the whole slot.
module parallel_serial_scheduler #(
   parameter int         NUM_REQ    = 4,
   parameter int         SYNC_SLOTS = 4,
   parameter logic [7:0] IDLE_BYTE  = 8'hBC,
   localparam int        GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk_32f,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 ser_valid,
   output logic [7:0]           ser_data,
   output logic [GW-1:0]        grant_id,
   output logic [2:0]           slot_cnt,
   output logic                 sync_done
);

   localparam int SCW = $clog2(SYNC_SLOTS + 1);

   typedef enum logic {
      SYNC,
      ACTIVE
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [SCW-1:0] sync_cnt;
   logic [GW-1:0]  last_grant;
   logic [GW-1:0]  winner;
   logic [GW-1:0]  cand;
   logic           found;
   logic           boundary;
   logic           sync_last;
   logic           arb_en;
   logic           grant;

   assign boundary  = (slot_cnt == 3'd7);
   assign sync_last = (state == SYNC) && (sync_cnt == SCW'(SYNC_SLOTS - 1));
   assign arb_en    = (state == ACTIVE) || sync_last;
   assign grant     = boundary && arb_en && found && !reset;

   // Scan starts just past the previous winner so every requester gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = GW'((int'(last_grant) + off) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state <= SYNC;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (boundary && sync_last) begin
         state_next = ACTIVE;
      end
   end

   // Outputs only move on the slot boundary so the converter sees a steady byte.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         slot_cnt   <= 3'd0;
         sync_cnt   <= '0;
         ser_valid  <= 1'b0;
         ser_data   <= IDLE_BYTE;
         grant_id   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
         sync_done  <= 1'b0;
      end else begin
         slot_cnt <= slot_cnt + 3'd1;
         if (boundary) begin
            if (state == SYNC) begin
               sync_cnt <= sync_cnt + 1'b1;
            end
            if (sync_last) begin
               sync_done <= 1'b1;
            end
            if (grant) begin
               ser_valid  <= 1'b1;
               ser_data   <= req_data[{winner, 3'b000} +: 8];
               grant_id   <= winner;
               last_grant <= winner;
            end else begin
               ser_valid <= 1'b0;
               ser_data  <= IDLE_BYTE;
            end
         end
      end
   end

endmodule

// File: tb/tb_parallel_serial_scheduler.sv
// Scoreboard bench: a slot-level reference model queues the expected slot contents
// and boundary grants; an independent monitor compares them against the scheduler.
module tb_parallel_serial_scheduler;

   localparam int         NUM_REQ    = 4;
   localparam int         SYNC_SLOTS = 4;
   localparam logic [7:0] IDLE_BYTE  = 8'hBC;

   typedef struct {
      bit         v;
      logic [7:0] d;
      int         gid;
   } slot_t;

   logic        clk_32f;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        ser_valid;
   logic [7:0]  ser_data;
   logic [1:0]  grant_id;
   logic [2:0]  slot_cnt;
   logic        sync_done;

   slot_t      slotQ[$];
   logic [3:0] readyQ[$];
   int         vectors;
   int         miscompares;
   int         lastM;
   int         gidM;
   int         slotM;

   parallel_serial_scheduler #(
      .NUM_REQ(NUM_REQ),
      .SYNC_SLOTS(SYNC_SLOTS),
      .IDLE_BYTE(IDLE_BYTE)
   ) dut (
      .clk_32f(clk_32f),
      .reset(reset),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .ser_valid(ser_valid),
      .ser_data(ser_data),
      .grant_id(grant_id),
      .slot_cnt(slot_cnt),
      .sync_done(sync_done)
   );

   initial clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Fresh sync period: slot 0 is idle and nothing has been granted yet.
   task automatic resetModel();
      slot_t e;
      slotQ.delete();
      readyQ.delete();
      lastM = NUM_REQ - 1;
      gidM  = 0;
      slotM = 0;
      e.v   = 1'b0;
      e.d   = IDLE_BYTE;
      e.gid = 0;
      slotQ.push_back(e);
   endtask

   // Decides the boundary of the current slot and queues what the next slot carries.
   task automatic modelSlot(input logic [3:0] v, input logic [31:0] d);
      slot_t       e;
      logic [3:0]  rdy;
      logic [31:0] sh;
      bit          found;
      int          i;
      e.v   = 1'b0;
      e.d   = IDLE_BYTE;
      rdy   = 4'b0000;
      found = 1'b0;
      if (slotM >= SYNC_SLOTS - 1) begin
         for (int off = 1; off <= NUM_REQ; off++) begin
            i = (lastM + off) % NUM_REQ;
            if (!found && ((v >> i) & 4'b0001) != 4'b0000) begin
               found = 1'b1;
               sh    = d >> (8 * i);
               e.v   = 1'b1;
               e.d   = sh[7:0];
               lastM = i;
               gidM  = i;
               rdy   = 4'(1 << i);
            end
         end
      end
      e.gid = gidM;
      slotQ.push_back(e);
      readyQ.push_back(rdy);
      slotM++;
   endtask

   // Drives one full slot; with glitch set, valid wanders until the boundary cycle.
   task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input bit glitch);
      modelSlot(v, d);
      req_data = d;
      for (int c = 0; c < 8; c++) begin
         if (glitch && c < 7) begin
            req_valid = 4'($urandom);
         end else begin
            req_valid = v;
         end
         @(posedge clk_32f);
         #1;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      req_valid   = 4'hF;
      req_data    = 32'h11223344;
      repeat (3) @(posedge clk_32f);
      #1;
      reset     = 1'b0;
      req_valid = 4'b0001;
      req_data  = 32'h000000FF;
      resetModel();

      for (int s = 0; s < SYNC_SLOTS; s++) applyStimulus(4'b0001, 32'h000000FF, 1'b0);

      applyStimulus(4'b1000, 32'hCC000000, 1'b0);
      for (int s = 0; s < 5; s++) applyStimulus(4'b1111, 32'hCCAAEEFF, 1'b0);

      applyStimulus(4'b0100, 32'h00AA0000, 1'b0);
      applyStimulus(4'b0011, 32'h0000EEFF, 1'b0);
      applyStimulus(4'b0011, 32'h0000EEFF, 1'b0);

      applyStimulus(4'b0000, 32'h12345678, 1'b0);

      for (int s = 0; s < 30; s++) applyStimulus(4'($urandom_range(0, 15)), $urandom, 1'b1);

      applyStimulus(4'b1000, 32'hCC000000, 1'b0);
      req_valid = 4'b0000;
      repeat (3) @(posedge clk_32f);
      #1;
      reset     = 1'b1;
      req_valid = 4'hF;
      slotQ.delete();
      readyQ.delete();
      repeat (2) @(posedge clk_32f);
      #1;
      reset = 1'b0;
      resetModel();

      for (int s = 0; s < SYNC_SLOTS; s++) applyStimulus(4'b1111, $urandom, 1'b0);
      for (int s = 0; s < 10; s++) applyStimulus(4'($urandom_range(0, 15)), $urandom, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Monitor: pops one slot expectation per slot start and one grant per boundary.
   initial begin
      slot_t      cur;
      logic [3:0] rdyExp;
      int         k;
      int         rstCycles;
      bit         haveCur;
      k         = 0;
      rstCycles = 0;
      haveCur   = 1'b0;
      forever begin
         @(negedge clk_32f);
         if (reset) begin
            checkOutput("req_ready_in_reset", int'(req_ready), 0);
            if (rstCycles > 0) begin
               checkOutput("reset_ser_valid", int'(ser_valid), 0);
               checkOutput("reset_ser_data", int'(ser_data), int'(IDLE_BYTE));
               checkOutput("reset_slot_cnt", int'(slot_cnt), 0);
               checkOutput("reset_sync_done", int'(sync_done), 0);
               checkOutput("reset_grant_id", int'(grant_id), 0);
            end
            rstCycles++;
            k       = 0;
            haveCur = 1'b0;
         end else begin
            rstCycles = 0;
            if (k % 8 == 0) begin
               if (slotQ.size() == 0) begin
                  checkOutput("slot_queue_underflow", 0, 1);
                  haveCur = 1'b0;
               end else begin
                  cur     = slotQ.pop_front();
                  haveCur = 1'b1;
               end
            end
            checkOutput("slot_cnt", int'(slot_cnt), k % 8);
            checkOutput("sync_done", int'(sync_done), int'(k >= 8 * SYNC_SLOTS));
            if (haveCur) begin
               checkOutput("ser_valid", int'(ser_valid), int'(cur.v));
               checkOutput("ser_data", int'(ser_data), int'(cur.d));
               checkOutput("grant_id", int'(grant_id), cur.gid);
            end
            if (k % 8 == 7) begin
               if (readyQ.size() == 0) begin
                  checkOutput("ready_queue_underflow", 0, 1);
               end else begin
                  rdyExp = readyQ.pop_front();
                  checkOutput("req_ready_boundary", int'(req_ready), int'(rdyExp));
               end
            end else begin
               checkOutput("req_ready_midslot", int'(req_ready), 0);
            end
            k++;
         end
      end
   end

endmodule
